// File: rtl/nkmd_uart_bridge_if.sv
// Byte-stream and peripheral-bus signals of the nkmd UART host bridge.
// The master modport is the bridge side; the slave modport is the uart core plus bus fabric side.
interface nkmd_uart_bridge_if;
    logic [7:0]  rx_data_i;
    logic        rx_ack_i;
    logic [7:0]  tx_data_o;
    logic        tx_ack_o;
    logic        tx_pop_i;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic        bus_we_o;
    logic [31:0] bus_data_i;

    modport master (
        input  rx_data_i, rx_ack_i, tx_pop_i, bus_data_i,
        output tx_data_o, tx_ack_o, bus_addr_o, bus_data_o, bus_we_o
    );

    modport slave (
        output rx_data_i, rx_ack_i, tx_pop_i, bus_data_i,
        input  tx_data_o, tx_ack_o, bus_addr_o, bus_data_o, bus_we_o
    );
endinterface

// File: rtl/nkmd_uart_bridge.sv
// Serial-to-bus debug initiator: parses 'W'/'R' host frames, runs one bus access, replies over tx.
// Optional inter-byte timeout is built when NKMD_UART_BRIDGE_TIMEOUT_EN is defined.
module nkmd_uart_bridge #(
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000,
    parameter int          TIMEOUT      = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    nkmd_uart_bridge_if.master        link,
    output logic                      busy_o,
    output logic                      overrun_o
);
    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA, WRITE, READ, NAK, SEND
    } state_t;

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        tx_ready_q, tx_ready_d;
    logic        overrun_q, overrun_d;
    logic        tx_fire;
    logic        gap_expired;

    assign tx_fire = (state_q == SEND) && tx_ready_q;

`ifdef NKMD_UART_BRIDGE_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             waiting;

    assign waiting     = state_q inside {ADDR_HI, ADDR_LO, DATA};
    assign gap_expired = waiting && !link.rx_ack_i && (gap_q == GAP_W'(TIMEOUT - 1));

    always_comb begin
        gap_d = '0;
        if (waiting && !link.rx_ack_i)
            gap_d = gap_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) gap_q <= '0;
        else      gap_q <= gap_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign gap_expired    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        tx_ready_d = link.tx_pop_i ? 1'b1 : (tx_fire ? 1'b0 : tx_ready_q);
        overrun_d  = overrun_q |
                     (link.rx_ack_i && (state_q inside {WRITE, READ, NAK, SEND}));

        case (state_q)
            IDLE: if (link.rx_ack_i) begin
                case (link.rx_data_i)
                    8'h57: begin is_write_d = 1'b1; state_d = ADDR_HI; end
                    8'h52: begin is_write_d = 1'b0; state_d = ADDR_HI; end
                    default: state_d = NAK;
                endcase
            end
            ADDR_HI: if (link.rx_ack_i) begin
                addr_d[15:8] = link.rx_data_i;
                state_d      = ADDR_LO;
            end
            ADDR_LO: if (link.rx_ack_i) begin
                addr_d[7:0] = link.rx_data_i;
                cnt_d       = 3'd0;
                state_d     = is_write_q ? DATA : READ;
            end
            DATA: if (link.rx_ack_i) begin
                data_d = {data_q[23:0], link.rx_data_i};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd3) state_d = WRITE;
            end
            WRITE: begin
                buf_d   = {8'h06, 24'h0};
                cnt_d   = 3'd1;
                state_d = SEND;
            end
            READ: begin
                // bus_data_i is taken at the end of the last latency cycle, then the address is released
                if (cnt_q == 3'(READ_LATENCY - 1)) begin
                    buf_d   = link.bus_data_i;
                    cnt_d   = 3'd4;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            NAK: begin
                buf_d   = {8'h15, 24'h0};
                cnt_d   = 3'd1;
                state_d = SEND;
            end
            SEND: if (tx_fire) begin
                buf_d = {buf_q[23:0], 8'h00};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (gap_expired) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 16'h0;
            data_q     <= 32'h0;
            buf_q      <= 32'h0;
            cnt_q      <= 3'd0;
            tx_ready_q <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            tx_ready_q <= tx_ready_d;
            overrun_q  <= overrun_d;
        end
    end

    assign link.tx_ack_o   = tx_fire;
    assign link.tx_data_o  = (state_q == SEND) ? buf_q[31:24] : 8'h00;
    assign link.bus_addr_o = (state_q inside {WRITE, READ}) ? {16'h0, addr_q} : IDLE_ADDR;
    assign link.bus_data_o = data_q;
    assign link.bus_we_o   = (state_q == WRITE);
    assign busy_o          = (state_q != IDLE);
    assign overrun_o       = overrun_q;
endmodule
